// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_arbiter
// Description : Round-robin arbiter giving NUM_CORES cores access to one shared
//               single-port RAM. Optional bus lock with MEM_ARBITER_LOCK_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_arbiter #(
    parameter int NUM_CORES  = 4,
    parameter int WIDTH      = 12,
    parameter int ADDR_WIDTH = 8
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [NUM_CORES-1:0]            req,
    input  logic [NUM_CORES-1:0]            wr,
    input  logic [NUM_CORES-1:0]            lock,
    input  logic [NUM_CORES*ADDR_WIDTH-1:0] addr,
    input  logic [NUM_CORES*WIDTH-1:0]      wdata,
    output logic [NUM_CORES-1:0]            gnt,
    output logic [NUM_CORES-1:0]            rvalid,
    output logic [WIDTH-1:0]                rdata,
    output logic                            ram_wrEn,
    output logic [ADDR_WIDTH-1:0]           ram_addr,
    output logic [WIDTH-1:0]                ram_dataIn,
    input  logic [WIDTH-1:0]                ram_dataOut
);

    localparam int PTR_W = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
    localparam logic [PTR_W-1:0] c_LAST = PTR_W'(NUM_CORES - 1);

    logic [PTR_W-1:0]     r_ptr;
    logic [NUM_CORES-1:0] r_rvalid;
    logic [NUM_CORES-1:0] w_req;
    logic [NUM_CORES-1:0] w_gnt;
    logic                 w_any;
    logic [PTR_W-1:0]     w_gidx;
    int                   w_idx;

    assign w_req = rst ? '0 : req;

`ifdef MEM_ARBITER_LOCK_EN
    logic             r_locked;
    logic [PTR_W-1:0] r_owner;
    logic             w_hold;

    // The owner keeps the bus only while it still requests and still locks.
    assign w_hold = r_locked && w_req[r_owner] && lock[r_owner];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_locked <= 1'b0;
            r_owner  <= '0;
        end else begin
            r_locked <= w_any && lock[w_gidx];
            r_owner  <= w_gidx;
        end
    end
`else
    logic w_unused_lock;
    assign w_unused_lock = ^lock;
`endif

    always_comb begin
        w_gnt  = '0;
        w_any  = 1'b0;
        w_gidx = '0;
        w_idx  = 0;
        for (int k = 0; k < NUM_CORES; k++) begin
            w_idx = int'(r_ptr) + k;
            if (w_idx >= NUM_CORES) w_idx = w_idx - NUM_CORES;
            if (!w_any && w_req[w_idx]) begin
                w_any  = 1'b1;
                w_gidx = PTR_W'(w_idx);
            end
        end
`ifdef MEM_ARBITER_LOCK_EN
        if (w_hold) begin
            w_any  = 1'b1;
            w_gidx = r_owner;
        end
`endif
        w_gnt[w_gidx] = w_any;
    end

    // A locked re-grant reloads the same pointer value, so ptr effectively holds.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ptr    <= '0;
            r_rvalid <= '0;
        end else begin
            if (w_any) r_ptr <= (w_gidx == c_LAST) ? '0 : w_gidx + 1'b1;
            r_rvalid <= w_gnt & ~wr;
        end
    end

    assign gnt        = w_gnt;
    assign ram_wrEn   = w_any & wr[w_gidx];
    assign ram_addr   = w_any ? addr[int'(w_gidx)*ADDR_WIDTH +: ADDR_WIDTH] : '0;
    assign ram_dataIn = w_any ? wdata[int'(w_gidx)*WIDTH +: WIDTH] : '0;

    // Gating with rst drops a read granted the cycle before reset asserts.
    assign rvalid = r_rvalid & {NUM_CORES{~rst}};
    assign rdata  = ram_dataOut;

endmodule
`default_nettype wire

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter NUM_CORES, default 4, number of requesting cores (2..8).
REQ-002 SHALL have parameter WIDTH, default 12, data word width.
REQ-003 SHALL have parameter ADDR_WIDTH, default 8, word address width.
REQ-004 SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-006 SHALL have port req, input, NUM_CORES, per-core access request.
REQ-007 SHALL have port wr, input, NUM_CORES, per-core write (1) or read (0) qualifier.
REQ-008 SHALL have port lock, input, NUM_CORES, per-core hold-bus request; used only with MEM_ARBITER_LOCK_EN.
REQ-009 SHALL have port addr, input, NUM_CORES*ADDR_WIDTH, per-core address; core i in slice i.
REQ-010 SHALL have port wdata, input, NUM_CORES*WIDTH, per-core write data; core i in slice i.
REQ-011 SHALL have port gnt, output, NUM_CORES, one-hot grant, combinational, same cycle as req.
REQ-012 SHALL have port rvalid, output, NUM_CORES, one-hot, read data valid for that core.
REQ-013 SHALL have port rdata, output, WIDTH, read data shared by all cores.
REQ-014 SHALL have ports ram_wrEn (output, 1), ram_addr (output, ADDR_WIDTH), ram_dataIn (output, WIDTH), ram_dataOut (input, WIDTH), to the downstream shared RAM, which registers wrEn/addr/dataIn on clk and drives dataOut from its registered address.

Function
REQ-015 SHALL grant at most one core per cycle; gnt[i] only if req[i].
REQ-016 SHALL select round-robin: the first requesting core at or after priority pointer ptr, wrapping NUM_CORES-1 to 0.
REQ-017 SHALL, after a grant to core g, load ptr with (g+1) mod NUM_CORES; ptr unchanged when no grant.
REQ-018 SHALL drive ram_addr, ram_dataIn from the granted core's slices and ram_wrEn = wr[g] when a grant exists, else ram_wrEn = 0 and ram_addr/ram_dataIn hold 0.
REQ-019 SHALL, for a granted read in cycle t, assert rvalid[g] for exactly cycle t+1 with rdata = ram_dataOut; latency one cycle.
REQ-020 SHALL hold rvalid all-zero for granted writes and idle cycles; rdata is don't-care when rvalid is zero.
REQ-021 SHALL support back-to-back grants every cycle, including reads to different cores in consecutive cycles, with no bubble.
REQ-022 SHALL return the new value for a read granted in cycle t+1 or later to an address written by a grant in cycle t; no forwarding logic is required because the RAM write and read-address register update on the same edge.
REQ-023 SHALL grant a lone requester every cycle regardless of ptr.

Reset
REQ-024 SHALL, while rst is high, force gnt = 0, ram_wrEn = 0, and suppress all requests.
REQ-025 SHALL on reset set ptr = 0, rvalid = 0, clear the pending-read register and the lock owner.
REQ-026 SHALL drop a read granted in the cycle before rst asserts (no rvalid after reset).

Configuration
REQ-027 SHALL, with macro MEM_ARBITER_LOCK_EN defined, keep the grant on core g in the next cycle whenever gnt[g], lock[g] and req[g] are all high, overriding round-robin; ptr is not advanced while locked; the lock releases the first cycle req[g] or lock[g] is low, and arbitration then restarts from ptr = (g+1) mod NUM_CORES.
REQ-028 SHALL, without MEM_ARBITER_LOCK_EN, ignore lock entirely and contain no lock-owner state.

Verification
REQ-029 SHALL cover: reset, then req = 4'b1111 held for 8 cycles -> gnt sequence 0001,0010,0100,1000, repeated.
REQ-030 SHALL cover: core 2 writes 0xABC to addr 0x10 in cycle t, then core 2 reads 0x10 in cycle t+1 -> rvalid = 4'b0100 in cycle t+2, rdata = 0xABC.
REQ-031 SHALL cover: cores 0 and 3 read addr 0x01 (holds 0x111) and addr 0x02 (holds 0x222) with both requests held -> rvalid 0001 with 0x111, then 1000 with 0x222, in consecutive cycles.
REQ-032 SHALL cover: read grant to core 1, rst high the next cycle -> rvalid stays 0, ptr = 0 afterwards.
REQ-033 SHALL cover (MEM_ARBITER_LOCK_EN): core 1 holds req and lock for 3 cycles while core 0 also requests -> gnt = 0010 for all 3 cycles, then 0001 after lock drops; without the macro -> gnt alternates 0010/0001.
